// File: rtl/fir_pkg.sv
// fir_pkg: shared state encoding and default geometry for the FIR delay-line controller.
package fir_pkg;

    localparam int ADDR_WIDTH_DEF = 4;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int NTAPS_DEF      = 16;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        FETCH,
        STREAM,
        CLEAR
    } state_t;

endpackage

// File: rtl/fir_dline_ctrl.sv
// fir_dline_ctrl: circular-buffer delay line over an external 1-cycle-latency SRAM, streaming NTAPS taps newest first.
// Define FIR_DLINE_CLEAR_EN to zero the whole SRAM after reset before accepting samples.
module fir_dline_ctrl
    import fir_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NTAPS      = NTAPS_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_din,
    output logic                  sram_wr,
    input  logic [DATA_WIDTH-1:0] sram_qout,
    output logic [DATA_WIDTH-1:0] tap_data,
    output logic [ADDR_WIDTH-1:0] tap_idx,
    output logic                  tap_valid,
    input  logic                  tap_ready,
    output logic                  tap_last,
    output logic                  busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_K = ADDR_WIDTH'(NTAPS - 1);

    generate
        if (NTAPS < 1 || NTAPS > DEPTH) begin : g_bad_ntaps
            $error("fir_dline_ctrl: NTAPS must be in 1..2**ADDR_WIDTH");
        end
    endgenerate

`ifdef FIR_DLINE_CLEAR_EN
    localparam state_t RST_STATE = CLEAR;
`else
    localparam state_t RST_STATE = IDLE;
`endif

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] k_q, k_d;
    logic [DATA_WIDTH-1:0] sample_q, sample_d;
    logic                  last;
    logic                  fire;

    always_comb begin
        last     = k_q == LAST_K;
        fire     = state_q == STREAM && tap_ready;
        state_d  = state_q;
        wptr_d   = wptr_q;
        k_d      = k_q;
        sample_d = sample_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sample_d = in_data;
                    state_d  = WRITE;
                end
            end
            WRITE: begin
                k_d     = '0;
                state_d = FETCH;
            end
            FETCH: state_d = STREAM;
            STREAM: begin
                if (tap_ready) begin
                    k_d     = last ? k_q : k_q + 1'b1;
                    wptr_d  = last ? wptr_q + 1'b1 : wptr_q;
                    state_d = last ? IDLE : STREAM;
                end
            end
            // wptr doubles as the clear address and wraps back to 0 on exit
            CLEAR: begin
                wptr_d  = wptr_q + 1'b1;
                state_d = wptr_q == '1 ? IDLE : CLEAR;
            end
            default: state_d = IDLE;
        endcase
    end

    // The look-ahead address on a non-last fire keeps one tap per cycle through the 1-cycle SRAM.
    always_comb begin
        in_ready  = state_q == IDLE;
        busy      = state_q != IDLE;
        sram_wr   = state_q == WRITE || state_q == CLEAR;
        sram_din  = state_q == WRITE ? sample_q : '0;
        sram_addr = state_q == STREAM ? wptr_q - ((fire && !last) ? k_q + 1'b1 : k_q) : wptr_q;
        tap_valid = state_q == STREAM;
        tap_data  = sram_qout;
        tap_idx   = k_q;
        tap_last  = state_q == STREAM && last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RST_STATE;
            wptr_q   <= '0;
            k_q      <= '0;
            sample_q <= '0;
        end else begin
            state_q  <= state_d;
            wptr_q   <= wptr_d;
            k_q      <= k_d;
            sample_q <= sample_d;
        end
    end

endmodule
